mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/arb_pkg.sv | 23 ++
 rtl/mem_arbiter_if.sv | 50 +++++
 rtl/rr_pick2.sv | 22 ++
 rtl/mem_arbiter.sv | 116 +++++++++++
 tb/tb_mem_arbiter.sv | 210 +++++++++++++++++++++
 5 files changed

// File: rtl/arb_pkg.sv
// Shared types and defaults for the two-port byte-memory arbiter.
// Port-select encoding: 0 = fetch port, 1 = data port.
package arb_pkg;

   localparam int ADDR_W_DEF = 16;
   localparam int BYTE_W_DEF = 8;

   typedef logic port_sel_t;

   localparam port_sel_t PORT_F = 1'b0;
   localparam port_sel_t PORT_D = 1'b1;

   typedef enum logic [2:0] {
      IDLE,
      RD_LO,
      RD_HI,
      RD_CAP,
      WR_LO,
      WR_HI,
      DONE
   } arb_state_e;

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of the fetch port, data port and byte-memory signals around mem_arbiter.
// The arbiter uses the slave view; requesters and memory use the master view.
interface mem_arbiter_if
   import arb_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int BYTE_W = BYTE_W_DEF
);

   logic                  arb_f_req;
   logic [ADDR_W-1:0]     arb_f_addr;
   logic                  arb_f_done;
   logic [2*BYTE_W-1:0]   arb_f_rdata;

   logic                  arb_d_req;
   logic                  arb_d_we;
   logic [ADDR_W-1:0]     arb_d_addr;
   logic [2*BYTE_W-1:0]   arb_d_wdata;
   logic                  arb_d_done;
   logic [2*BYTE_W-1:0]   arb_d_rdata;

   logic [ADDR_W-1:0]     arb_mem_addr;
   logic [BYTE_W-1:0]     arb_mem_wdata;
   logic                  arb_mem_rd_en;
   logic                  arb_mem_wr_en;
   logic [BYTE_W-1:0]     arb_mem_rdata;

   logic                  arb_busy;

   modport slave (
      input  arb_f_req, arb_f_addr,
      input  arb_d_req, arb_d_we, arb_d_addr, arb_d_wdata,
      input  arb_mem_rdata,
      output arb_f_done, arb_f_rdata,
      output arb_d_done, arb_d_rdata,
      output arb_mem_addr, arb_mem_wdata, arb_mem_rd_en, arb_mem_wr_en,
      output arb_busy
   );

   modport master (
      output arb_f_req, arb_f_addr,
      output arb_d_req, arb_d_we, arb_d_addr, arb_d_wdata,
      output arb_mem_rdata,
      input  arb_f_done, arb_f_rdata,
      input  arb_d_done, arb_d_rdata,
      input  arb_mem_addr, arb_mem_wdata, arb_mem_rd_en, arb_mem_wr_en,
      input  arb_busy
   );

endinterface

// File: rtl/rr_pick2.sv
// Two-way round-robin pick: a lone requester wins, a tie goes to the port
// that was not served last.
module rr_pick2
   import arb_pkg::*;
(
   input  logic [1:0] req,
   input  port_sel_t  last,
   output port_sel_t  grant
);

   // Bit 0 of req is the fetch port, bit 1 the data port.
   always_comb begin
      grant = PORT_F;
      case (req)
         2'b01:   grant = PORT_F;
         2'b10:   grant = PORT_D;
         2'b11:   grant = (last == PORT_D) ? PORT_F : PORT_D;
         default: grant = PORT_F;
      endcase
   end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates a read-only fetch port and a read/write data port onto one
// byte-wide memory; every word transfer is two byte accesses at A and A+1.
module mem_arbiter
   import arb_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int BYTE_W = BYTE_W_DEF
) (
   input logic          arb_clk,
   input logic          arb_rst_n,
   mem_arbiter_if.slave bus
);

   arb_state_e          state;
   arb_state_e          nxt_state;
   port_sel_t           sel_q;
   port_sel_t           last_q;
   port_sel_t           grant;
   logic [1:0]          req_vec;
   logic                any_req;
   logic [ADDR_W-1:0]   addr_q;
   logic [ADDR_W-1:0]   win_addr;
   logic [ADDR_W-1:0]   nxt_addr;
   logic                win_we;
   logic [BYTE_W-1:0]   wdata_hi_q;
   logic [BYTE_W-1:0]   lo_q;
   logic [BYTE_W-1:0]   nxt_wdata;

   assign req_vec  = {bus.arb_d_req, bus.arb_f_req};
   assign any_req  = |req_vec;
   assign win_addr = (grant == PORT_D) ? bus.arb_d_addr : bus.arb_f_addr;
   assign win_we   = (grant == PORT_D) && bus.arb_d_we;

   rr_pick2 u_pick (
      .req   (req_vec),
      .last  (last_q),
      .grant (grant)
   );

   // Next state plus the memory-side values that state will drive; the
   // address for the high byte wraps naturally at ADDR_W bits.
   always_comb begin
      nxt_state = state;
      nxt_addr  = '0;
      nxt_wdata = '0;
      case (state)
         IDLE:    if (any_req) nxt_state = win_we ? WR_LO : RD_LO;
         RD_LO:   nxt_state = RD_HI;
         RD_HI:   nxt_state = RD_CAP;
         RD_CAP:  nxt_state = DONE;
         WR_LO:   nxt_state = WR_HI;
         WR_HI:   nxt_state = DONE;
         DONE:    nxt_state = IDLE;
         default: nxt_state = IDLE;
      endcase
      case (nxt_state)
         RD_LO: nxt_addr = win_addr;
         WR_LO: begin
            nxt_addr  = win_addr;
            nxt_wdata = bus.arb_d_wdata[BYTE_W-1:0];
         end
         RD_HI: nxt_addr = addr_q + ADDR_W'(1);
         WR_HI: begin
            nxt_addr  = addr_q + ADDR_W'(1);
            nxt_wdata = wdata_hi_q;
         end
         default: ;
      endcase
   end

   // All outputs are registered from the next state, so each one is a pure
   // function of the current state and the transfer latched at grant.
   always_ff @(posedge arb_clk or negedge arb_rst_n) begin
      if (!arb_rst_n) begin
         state             <= IDLE;
         sel_q             <= PORT_F;
         last_q            <= PORT_D;
         addr_q            <= '0;
         wdata_hi_q        <= '0;
         lo_q              <= '0;
         bus.arb_mem_addr  <= '0;
         bus.arb_mem_wdata <= '0;
         bus.arb_mem_rd_en <= 1'b0;
         bus.arb_mem_wr_en <= 1'b0;
         bus.arb_busy      <= 1'b0;
         bus.arb_f_done    <= 1'b0;
         bus.arb_d_done    <= 1'b0;
         bus.arb_f_rdata   <= '0;
         bus.arb_d_rdata   <= '0;
      end else begin
         state             <= nxt_state;
         bus.arb_mem_addr  <= nxt_addr;
         bus.arb_mem_wdata <= nxt_wdata;
         bus.arb_mem_rd_en <= (nxt_state == RD_LO) || (nxt_state == RD_HI);
         bus.arb_mem_wr_en <= (nxt_state == WR_LO) || (nxt_state == WR_HI);
         bus.arb_busy      <= (nxt_state != IDLE);
         bus.arb_f_done    <= (nxt_state == DONE) && (sel_q == PORT_F);
         bus.arb_d_done    <= (nxt_state == DONE) && (sel_q == PORT_D);

         if ((state == IDLE) && any_req) begin
            sel_q      <= grant;
            last_q     <= grant;
            addr_q     <= win_addr;
            wdata_hi_q <= bus.arb_d_wdata[2*BYTE_W-1:BYTE_W];
         end

         if (state == RD_HI) lo_q <= bus.arb_mem_rdata;

         if (state == RD_CAP) begin
            if (sel_q == PORT_F) bus.arb_f_rdata <= {bus.arb_mem_rdata, lo_q};
            else                 bus.arb_d_rdata <= {bus.arb_mem_rdata, lo_q};
         end
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a registered-read byte memory model;
// expected values are hand-computed constants.
module tb_mem_arbiter;

   logic arb_clk = 1'b0;
   logic arb_rst_n;

   always #5 arb_clk = ~arb_clk;

   mem_arbiter_if #(.ADDR_W(16), .BYTE_W(8)) bus ();

   mem_arbiter #(.ADDR_W(16), .BYTE_W(8)) dut (
      .arb_clk   (arb_clk),
      .arb_rst_n (arb_rst_n),
      .bus       (bus.slave)
   );

   logic [7:0] mem [0:65535];

   // Byte memory: read data appears the cycle after rd_en; preloaded in reset.
   always @(posedge arb_clk) begin
      if (!arb_rst_n) begin
         mem[16'h0006] <= 8'h47;
         mem[16'h0007] <= 8'h8E;
      end else begin
         if (bus.arb_mem_rd_en) bus.arb_mem_rdata <= mem[bus.arb_mem_addr];
         if (bus.arb_mem_wr_en) mem[bus.arb_mem_addr] <= bus.arb_mem_wdata;
      end
   end

   int errors = 0;
   int checks = 0;

   int          rd_cnt, wr_cnt, both_cnt, f_done_cnt, d_done_cnt, first_done, consec;
   logic [7:0]  seq;
   logic [15:0] addr_at1, addr_at2, addr_done;
   logic [7:0]  wdata_at1, wdata_at2;
   logic        prev_done;

   task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic apply_stimulus(input logic f_req, input logic [15:0] f_addr,
                                 input logic d_req, input logic d_we,
                                 input logic [15:0] d_addr, input logic [15:0] d_wdata);
      bus.arb_f_req   = f_req;
      bus.arb_f_addr  = f_addr;
      bus.arb_d_req   = d_req;
      bus.arb_d_we    = d_we;
      bus.arb_d_addr  = d_addr;
      bus.arb_d_wdata = d_wdata;
   endtask

   task automatic drop_requests();
      bus.arb_f_req = 1'b0;
      bus.arb_d_req = 1'b0;
   endtask

   // Steps n cycles, sampling 1 time unit after each rising edge; requests are
   // dropped after cycle 1 (drop_after == 0) or at the drop_after-th done.
   task automatic run_cycles(input int n, input int drop_after);
      rd_cnt = 0; wr_cnt = 0; both_cnt = 0; f_done_cnt = 0; d_done_cnt = 0;
      first_done = 0; consec = 0; seq = '0; prev_done = 1'b0;
      addr_at1 = '0; addr_at2 = '0; addr_done = '0; wdata_at1 = '0; wdata_at2 = '0;
      for (int k = 1; k <= n; k++) begin
         @(posedge arb_clk);
         #1;
         if (k == 1) begin addr_at1 = bus.arb_mem_addr; wdata_at1 = bus.arb_mem_wdata; end
         if (k == 2) begin addr_at2 = bus.arb_mem_addr; wdata_at2 = bus.arb_mem_wdata; end
         if (bus.arb_mem_rd_en) rd_cnt++;
         if (bus.arb_mem_wr_en) wr_cnt++;
         if (bus.arb_mem_rd_en && bus.arb_mem_wr_en) both_cnt++;
         if (bus.arb_f_done && bus.arb_d_done) both_cnt++;
         if (bus.arb_f_done) f_done_cnt++;
         if (bus.arb_d_done) d_done_cnt++;
         if (bus.arb_f_done || bus.arb_d_done) begin
            if (first_done == 0) begin
               first_done = k;
               addr_done  = bus.arb_mem_addr;
            end
            if (prev_done) consec++;
            seq = {seq[6:0], bus.arb_d_done};
            if ((f_done_cnt + d_done_cnt) == drop_after) drop_requests();
         end
         prev_done = bus.arb_f_done || bus.arb_d_done;
         if ((drop_after == 0) && (k == 1)) drop_requests();
      end
   endtask

   initial begin
      arb_rst_n = 1'b0;
      apply_stimulus(1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000);
      repeat (3) @(posedge arb_clk);
      #1;
      check_output("rst_busy",   bus.arb_busy,      0);
      check_output("rst_rd_en",  bus.arb_mem_rd_en, 0);
      check_output("rst_wr_en",  bus.arb_mem_wr_en, 0);
      check_output("rst_f_done", bus.arb_f_done,    0);
      check_output("rst_d_done", bus.arb_d_done,    0);
      check_output("rst_f_rd",   bus.arb_f_rdata,   0);
      check_output("rst_d_rd",   bus.arb_d_rdata,   0);
      check_output("rst_addr",   bus.arb_mem_addr,  0);
      check_output("rst_wdata",  bus.arb_mem_wdata, 0);
      @(negedge arb_clk);
      arb_rst_n = 1'b1;
      @(posedge arb_clk);
      #1;

      $display("[TB] fetch read 0x0006");
      apply_stimulus(1'b1, 16'h0006, 1'b0, 1'b0, 16'h0000, 16'h0000);
      run_cycles(6, 0);
      check_output("s1_rd_cycles", rd_cnt,          2);
      check_output("s1_done_cyc",  first_done,      4);
      check_output("s1_f_dones",   f_done_cnt,      1);
      check_output("s1_d_dones",   d_done_cnt,      0);
      check_output("s1_addr_lo",   addr_at1,        16'h0006);
      check_output("s1_addr_hi",   addr_at2,        16'h0007);
      check_output("s1_addr_done", addr_done,       0);
      check_output("s1_f_rdata",   bus.arb_f_rdata, 16'h8E47);
      check_output("s1_busy_end",  bus.arb_busy,    0);

      $display("[TB] data write 0x1234 to 0x0100");
      apply_stimulus(1'b0, 16'h0000, 1'b1, 1'b1, 16'h0100, 16'h1234);
      run_cycles(5, 0);
      check_output("s2w_wr_cycles", wr_cnt,          2);
      check_output("s2w_rd_cycles", rd_cnt,          0);
      check_output("s2w_done_cyc",  first_done,      3);
      check_output("s2w_d_dones",   d_done_cnt,      1);
      check_output("s2w_wdata_lo",  wdata_at1,       8'h34);
      check_output("s2w_wdata_hi",  wdata_at2,       8'h12);
      check_output("s2w_mem_lo",    mem[16'h0100],   8'h34);
      check_output("s2w_mem_hi",    mem[16'h0101],   8'h12);
      check_output("s2w_d_rdata",   bus.arb_d_rdata, 0);
      check_output("s2w_f_hold",    bus.arb_f_rdata, 16'h8E47);

      $display("[TB] data read 0x0100");
      apply_stimulus(1'b0, 16'h0000, 1'b1, 1'b0, 16'h0100, 16'h0000);
      run_cycles(6, 0);
      check_output("s2r_done_cyc", first_done,      4);
      check_output("s2r_d_dones",  d_done_cnt,      1);
      check_output("s2r_f_dones",  f_done_cnt,      0);
      check_output("s2r_d_rdata",  bus.arb_d_rdata, 16'h1234);

      $display("[TB] simultaneous fetch and data reads held");
      apply_stimulus(1'b1, 16'h0006, 1'b1, 1'b0, 16'h0100, 16'h0000);
      run_cycles(24, 4);
      check_output("s3_dones",     f_done_cnt + d_done_cnt, 4);
      check_output("s3_order",     seq[3:0],        4'b0101);
      check_output("s3_rd_cycles", rd_cnt,          8);
      check_output("s3_excl",      both_cnt,        0);
      check_output("s3_f_rdata",   bus.arb_f_rdata, 16'h8E47);
      check_output("s3_d_rdata",   bus.arb_d_rdata, 16'h1234);

      $display("[TB] data write 0xBEEF to 0xFFFF");
      apply_stimulus(1'b0, 16'h0000, 1'b1, 1'b1, 16'hFFFF, 16'hBEEF);
      run_cycles(5, 0);
      check_output("s4_addr_lo", addr_at1,       16'hFFFF);
      check_output("s4_addr_hi", addr_at2,       16'h0000);
      check_output("s4_mem_lo",  mem[16'hFFFF],  8'hEF);
      check_output("s4_mem_hi",  mem[16'h0000],  8'hBE);

      $display("[TB] fetch request held through DONE");
      apply_stimulus(1'b1, 16'hFFFF, 1'b0, 1'b0, 16'h0000, 16'h0000);
      run_cycles(12, 2);
      check_output("s6_f_dones",   f_done_cnt,      2);
      check_output("s6_consec",    consec,          0);
      check_output("s6_done_cyc",  first_done,      4);
      check_output("s6_rd_cycles", rd_cnt,          4);
      check_output("s6_f_rdata",   bus.arb_f_rdata, 16'hBEEF);
      check_output("s6_busy_end",  bus.arb_busy,    0);

      $display("[TB] reset pulse during RD_HI");
      apply_stimulus(1'b1, 16'h0006, 1'b0, 1'b0, 16'h0000, 16'h0000);
      @(posedge arb_clk);
      #1;
      drop_requests();
      @(posedge arb_clk);
      #1;
      check_output("s5_rdhi_rd_en", bus.arb_mem_rd_en, 1);
      check_output("s5_rdhi_addr",  bus.arb_mem_addr,  16'h0007);
      #2;
      arb_rst_n = 1'b0;
      #1;
      check_output("s5_rst_rd_en",  bus.arb_mem_rd_en, 0);
      check_output("s5_rst_busy",   bus.arb_busy,      0);
      check_output("s5_rst_f_rd",   bus.arb_f_rdata,   0);
      check_output("s5_rst_d_rd",   bus.arb_d_rdata,   0);
      #2;
      arb_rst_n = 1'b1;
      run_cycles(5, 0);
      check_output("s5_no_done", f_done_cnt + d_done_cnt, 0);
      check_output("s5_no_rd",   rd_cnt,                  0);
      apply_stimulus(1'b1, 16'h0006, 1'b1, 1'b0, 16'h0100, 16'h0000);
      run_cycles(6, 1);
      check_output("s5_tie_addr",  addr_at1,        16'h0006);
      check_output("s5_tie_f",     f_done_cnt,      1);
      check_output("s5_tie_d",     d_done_cnt,      0);
      check_output("s5_tie_cyc",   first_done,      4);
      check_output("s5_f_rdata",   bus.arb_f_rdata, 16'h8E47);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
